// File: rtl/usb_pkg.sv
// Shared constants and state encoding for the USB receive path.
package usb_pkg;

  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PID,
    ST_DATA,
    ST_CHECK,
    ST_ACK,
    ST_NAK,
    ST_DROP
  } rx_state_t;

  // A PID byte carries its code in the low nibble and the complement in the high nibble.
  function automatic logic pid_is_data(input logic [7:0] pid);
    return (pid[3:0] == ~pid[7:4]) &&
           ((pid[3:0] == PID_DATA0) || (pid[3:0] == PID_DATA1));
  endfunction

endpackage

// File: rtl/usb_crc_strip_pipe.sv
// Two-byte delay line that holds back the trailing CRC16 bytes of a packet.
// A byte only leaves the pipe once two newer bytes have arrived behind it,
// so the final two bytes of every packet are never forwarded.
module usb_crc_strip_pipe (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       push,
  input  logic       flush,
  input  logic [7:0] in_data,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       full
);

  logic [7:0] older;
  logic [7:0] newer;
  logic [1:0] fill;

  assign full      = (fill == 2'd2);
  assign out_valid = push && full && !flush;
  assign out_data  = older;

  // Shift a new byte in on push; flush empties the pipe between packets.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      fill  <= 2'd0;
      older <= 8'h00;
      newer <= 8'h00;
    end else if (flush) begin
      fill <= 2'd0;
    end else if (push) begin
      older <= newer;
      newer <= in_data;
      if (!full) begin
        fill <= fill + 2'd1;
      end
    end
  end

endmodule

// File: rtl/usb_rx_pkt_ctrl.sv
// Receive-side packet sequencer between the PHY byte stream and the
// commit/rollback RX FIFO. Accepts OUT DATA0/DATA1 payloads, strips CRC,
// enforces size and space limits, commits good packets and requests the
// ACK/NAK handshake from the transmit side.
import usb_pkg::*;

module usb_rx_pkt_ctrl #(
  parameter int ASIZE  = 9,
  parameter int MAXPKT = 64
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             rx_act,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  input  logic             rx_err,
  input  logic             crc16_ok,
  input  logic             ep_en,
  input  logic             toggle_clr,
  input  logic [ASIZE:0]   fifo_wrnum,
  input  logic             fifo_full,
  output logic             fifo_write,
  output logic [7:0]       fifo_data,
  output logic             fifo_pktval,
  output logic             fifo_rxact,
  output logic             hs_req,
  output logic [3:0]       hs_pid,
  output logic [ASIZE:0]   pkt_len,
  output logic             toggle
);

  localparam logic [ASIZE:0]   CNT_MAX    = (ASIZE+1)'(MAXPKT);
  localparam logic [ASIZE:0]   CNT_SAT    = (ASIZE+1)'(MAXPKT + 1);
  localparam logic [ASIZE+1:0] FIFO_DEPTH = (ASIZE+2)'(2**ASIZE);
  localparam logic [ASIZE+1:0] SPACE_NEED = (ASIZE+2)'(MAXPKT + 2);

  rx_state_t        state;
  logic             nak;
  logic             pid_tog;
  logic [ASIZE:0]   bytecount;

  logic             pipe_push;
  logic             pipe_flush;
  logic             pipe_out_valid;
  logic [7:0]       pipe_out_data;
  logic             pipe_full;

  logic [ASIZE+1:0] free_space;
  logic             low_space;
  logic             over_size;
  logic             data_drop;

  assign free_space = FIFO_DEPTH - {1'b0, fifo_wrnum};
  assign low_space  = (free_space < SPACE_NEED);

  assign pipe_push  = (state == ST_DATA) && rx_valid && !rx_err;
  assign pipe_flush = (state != ST_DATA);

  assign over_size  = (bytecount == CNT_MAX);
  assign data_drop  = pipe_out_valid && (over_size || (!nak && fifo_full));

  usb_crc_strip_pipe u_pipe (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .push      (pipe_push),
    .flush     (pipe_flush),
    .in_data   (rx_data),
    .out_valid (pipe_out_valid),
    .out_data  (pipe_out_data),
    .full      (pipe_full)
  );

  // Packet sequencing FSM with all FIFO and handshake outputs registered.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state       <= ST_IDLE;
      nak         <= 1'b0;
      pid_tog     <= 1'b0;
      bytecount   <= '0;
      fifo_write  <= 1'b0;
      fifo_data   <= 8'h00;
      fifo_pktval <= 1'b0;
      fifo_rxact  <= 1'b0;
      hs_req      <= 1'b0;
      hs_pid      <= 4'h0;
      pkt_len     <= '0;
      toggle      <= 1'b0;
    end else begin
      fifo_write  <= 1'b0;
      fifo_pktval <= 1'b0;
      hs_req      <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (rx_act) begin
            state      <= ST_PID;
            fifo_rxact <= 1'b1;
            nak        <= 1'b0;
            bytecount  <= '0;
          end
        end

        ST_PID: begin
          if (rx_err) begin
            state <= ST_DROP;
          end else if (rx_valid) begin
            if (!pid_is_data(rx_data)) begin
              state <= ST_DROP;
            end else begin
              state     <= ST_DATA;
              pid_tog   <= rx_data[3];
              nak       <= !ep_en || low_space;
              bytecount <= '0;
            end
          end else if (!rx_act) begin
            state      <= ST_IDLE;
            fifo_rxact <= 1'b0;
          end
        end

        ST_DATA: begin
          if (rx_err || data_drop) begin
            state <= ST_DROP;
            if (data_drop && over_size) begin
              bytecount <= CNT_SAT;
            end
          end else begin
            if (pipe_out_valid) begin
              bytecount <= bytecount + 1'b1;
              if (!nak) begin
                fifo_write <= 1'b1;
                fifo_data  <= pipe_out_data;
              end
            end
            if (!rx_act) begin
              state <= ST_CHECK;
            end
          end
        end

        ST_CHECK: begin
          if (rx_err || !crc16_ok || !pipe_full) begin
            state      <= ST_IDLE;
            fifo_rxact <= 1'b0;
          end else if (nak) begin
            state  <= ST_NAK;
            hs_req <= 1'b1;
            hs_pid <= PID_NAK;
          end else begin
            state  <= ST_ACK;
            hs_req <= 1'b1;
            hs_pid <= PID_ACK;
            if (pid_tog == toggle) begin
              fifo_pktval <= 1'b1;
              pkt_len     <= bytecount;
              toggle      <= ~toggle;
            end
          end
        end

        ST_ACK, ST_NAK: begin
          if (rx_err) begin
            state <= ST_DROP;
          end else begin
            state      <= ST_IDLE;
            fifo_rxact <= 1'b0;
          end
        end

        ST_DROP: begin
          if (!rx_act) begin
            state      <= ST_IDLE;
            fifo_rxact <= 1'b0;
          end
        end

        default: begin
          state      <= ST_IDLE;
          fifo_rxact <= 1'b0;
        end
      endcase

      if (toggle_clr) begin
        toggle <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_usb_rx_pkt_ctrl.sv
// Directed bench for the USB receive packet sequencer. A small commit/rollback
// FIFO model tracks what would be readable from the real FIFO.
module tb_usb_rx_pkt_ctrl;

  localparam int ASIZE  = 9;
  localparam int MAXPKT = 64;

  logic             CLK = 1'b0;
  logic             RSTn;
  logic             rx_act;
  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             rx_err;
  logic             crc16_ok;
  logic             ep_en;
  logic             toggle_clr;
  logic [ASIZE:0]   fifo_wrnum;
  logic             fifo_full;
  logic             fifo_write;
  logic [7:0]       fifo_data;
  logic             fifo_pktval;
  logic             fifo_rxact;
  logic             hs_req;
  logic [3:0]       hs_pid;
  logic [ASIZE:0]   pkt_len;
  logic             toggle;

  int n_checks = 0;
  int n_pass   = 0;

  int cyc = 0;
  int wr_cnt, pv_cnt, hs_cnt, overlap;
  int first_wr_cyc, pv_cyc, rise_cyc, fall_cyc;
  logic [3:0] last_hs_pid;
  logic       prev_rxact = 1'b0;
  logic [7:0] wr_q[$];
  logic [7:0] pend_q[$];
  logic [7:0] comm_q[$];
  logic [7:0] pay[0:69];
  logic [7:0] exp_comm[0:6];

  usb_rx_pkt_ctrl #(.ASIZE(ASIZE), .MAXPKT(MAXPKT)) dut (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .rx_act      (rx_act),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_err      (rx_err),
    .crc16_ok    (crc16_ok),
    .ep_en       (ep_en),
    .toggle_clr  (toggle_clr),
    .fifo_wrnum  (fifo_wrnum),
    .fifo_full   (fifo_full),
    .fifo_write  (fifo_write),
    .fifo_data   (fifo_data),
    .fifo_pktval (fifo_pktval),
    .fifo_rxact  (fifo_rxact),
    .hs_req      (hs_req),
    .hs_pid      (hs_pid),
    .pkt_len     (pkt_len),
    .toggle      (toggle)
  );

  // Free-running clock.
  always #5 CLK = ~CLK;

  // Cycle counter for latency measurements.
  always @(posedge CLK) cyc <= cyc + 1;

  // Observe outputs on the falling edge and model the FIFO's commit/rollback.
  always @(negedge CLK) begin
    if (fifo_rxact && !prev_rxact) begin
      pend_q.delete();
      rise_cyc = cyc;
    end
    prev_rxact = fifo_rxact;
    if (fifo_write) begin
      wr_cnt++;
      wr_q.push_back(fifo_data);
      pend_q.push_back(fifo_data);
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
    end
    if (fifo_pktval) begin
      pv_cnt++;
      pv_cyc = cyc;
      if (fifo_write) overlap++;
      foreach (pend_q[i]) comm_q.push_back(pend_q[i]);
      pend_q.delete();
    end
    if (hs_req) begin
      hs_cnt++;
      last_hs_pid = hs_pid;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic fillPayload(input int n, input logic [7:0] start);
    for (int i = 0; i < n; i++) pay[i] = start + 8'(i);
  endtask

  // Send PID, n payload bytes and two CRC bytes, each data byte followed by an idle cycle.
  task automatic applyStimulus(input logic [7:0] pid, input int n, input logic crc_ok,
                               input int err_idx, input logic clr);
    wr_cnt = 0; pv_cnt = 0; hs_cnt = 0; overlap = 0;
    first_wr_cyc = -1; pv_cyc = -1; last_hs_pid = 4'h0;
    wr_q.delete();
    pay[n]     = 8'hA5;
    pay[n + 1] = 8'h5A;
    crc16_ok   = crc_ok;
    @(negedge CLK); rx_act = 1'b1;
    @(negedge CLK); rx_valid = 1'b1; rx_data = pid;
    @(negedge CLK); rx_valid = 1'b0;
    for (int i = 0; i < n + 2; i++) begin
      @(negedge CLK); rx_valid = 1'b1; rx_data = pay[i]; rx_err = (i == err_idx);
      @(negedge CLK); rx_valid = 1'b0; rx_err = 1'b0;
    end
    @(negedge CLK); rx_act = 1'b0; fall_cyc = cyc;
    @(negedge CLK); toggle_clr = clr;
    @(negedge CLK); toggle_clr = 1'b0;
    repeat (4) @(negedge CLK);
  endtask

  task automatic checkPacket(input string tag, input int wr, input int pv, input int hs,
                             input logic [3:0] pid);
    checkOutput({tag, "_writes"}, wr_cnt, wr);
    checkOutput({tag, "_pktval"}, pv_cnt, pv);
    checkOutput({tag, "_hsreq"}, hs_cnt, hs);
    checkOutput({tag, "_hspid"}, last_hs_pid, pid);
    checkOutput({tag, "_overlap"}, overlap, 0);
    checkOutput({tag, "_rxact_idle"}, fifo_rxact, 0);
  endtask

  // Directed test sequence.
  initial begin
    RSTn = 1'b0; rx_act = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; rx_err = 1'b0;
    crc16_ok = 1'b1; ep_en = 1'b1; toggle_clr = 1'b0; fifo_wrnum = '0; fifo_full = 1'b0;
    repeat (3) @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);
    checkOutput("rst_write", fifo_write, 0);
    checkOutput("rst_data", fifo_data, 0);
    checkOutput("rst_pktval", fifo_pktval, 0);
    checkOutput("rst_rxact", fifo_rxact, 0);
    checkOutput("rst_hsreq", hs_req, 0);
    checkOutput("rst_hspid", hs_pid, 0);
    checkOutput("rst_pktlen", pkt_len, 0);
    checkOutput("rst_toggle", toggle, 0);

    $display("[TB] good DATA0 packet");
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
    applyStimulus(8'hC3, 4, 1'b1, -1, 1'b0);
    checkPacket("t1", 4, 1, 1, 4'h2);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("t1_data%0d", i), wr_q[i], 8'h11 * (i + 1));
    checkOutput("t1_pktval_delay", pv_cyc - fall_cyc, 2);
    checkOutput("t1_first_wr_gap", (first_wr_cyc - rise_cyc) >= 3, 1);
    checkOutput("t1_pktlen", pkt_len, 4);
    checkOutput("t1_toggle", toggle, 1);

    $display("[TB] DATA0 retransmission");
    applyStimulus(8'hC3, 4, 1'b1, -1, 1'b0);
    checkPacket("t2", 4, 0, 1, 4'h2);
    checkOutput("t2_toggle", toggle, 1);
    checkOutput("t2_pktlen", pkt_len, 4);

    $display("[TB] CRC error then good DATA1");
    fillPayload(8, 8'h80);
    applyStimulus(8'h4B, 8, 1'b0, -1, 1'b0);
    checkPacket("t3", 8, 0, 0, 4'h0);
    checkOutput("t3_toggle", toggle, 1);
    pay[0] = 8'h55; pay[1] = 8'h66; pay[2] = 8'h77;
    applyStimulus(8'h4B, 3, 1'b1, -1, 1'b0);
    checkPacket("t3b", 3, 1, 1, 4'h2);
    checkOutput("t3b_pktlen", pkt_len, 3);
    checkOutput("t3b_toggle", toggle, 0);
    exp_comm[0] = 8'h11; exp_comm[1] = 8'h22; exp_comm[2] = 8'h33; exp_comm[3] = 8'h44;
    exp_comm[4] = 8'h55; exp_comm[5] = 8'h66; exp_comm[6] = 8'h77;
    checkOutput("t3b_fifo_size", comm_q.size(), 7);
    for (int i = 0; i < 7; i++) checkOutput($sformatf("t3b_fifo%0d", i), comm_q[i], exp_comm[i]);

    $display("[TB] low FIFO space gives NAK");
    fifo_wrnum = 10'(512 - 40);
    fillPayload(4, 8'h20);
    applyStimulus(8'hC3, 4, 1'b1, -1, 1'b0);
    checkPacket("t4", 0, 0, 1, 4'hA);
    checkOutput("t4_toggle", toggle, 0);
    fifo_wrnum = '0;

    $display("[TB] endpoint disabled gives NAK");
    ep_en = 1'b0;
    applyStimulus(8'hC3, 4, 1'b1, -1, 1'b0);
    checkPacket("t5", 0, 0, 1, 4'hA);
    ep_en = 1'b1;

    $display("[TB] PHY error mid packet");
    fillPayload(6, 8'h30);
    applyStimulus(8'hC3, 6, 1'b1, 4, 1'b0);
    checkPacket("t6", 2, 0, 0, 4'h0);

    $display("[TB] oversize packet");
    fillPayload(66, 8'h00);
    applyStimulus(8'hC3, 66, 1'b1, -1, 1'b0);
    checkPacket("t7", 64, 0, 0, 4'h0);
    checkOutput("t7_toggle", toggle, 0);
    checkOutput("t7_pktlen", pkt_len, 3);

    $display("[TB] maximum size packet");
    fillPayload(64, 8'h00);
    applyStimulus(8'hC3, 64, 1'b1, -1, 1'b0);
    checkPacket("t8", 64, 1, 1, 4'h2);
    checkOutput("t8_pktlen", pkt_len, 64);
    checkOutput("t8_toggle", toggle, 1);
    checkOutput("t8_fifo_size", comm_q.size(), 71);
    checkOutput("t8_fifo_last", comm_q[70], 8'h3F);

    $display("[TB] bad PID byte");
    fillPayload(4, 8'h40);
    applyStimulus(8'hC4, 4, 1'b1, -1, 1'b0);
    checkPacket("t9", 0, 0, 0, 4'h0);
    checkOutput("t9_toggle", toggle, 1);

    $display("[TB] toggle clear");
    @(negedge CLK); toggle_clr = 1'b1;
    @(negedge CLK); toggle_clr = 1'b0;
    checkOutput("t10_toggle", toggle, 0);

    $display("[TB] toggle clear during committing ACK, space exactly enough");
    fifo_wrnum = 10'(512 - 66);
    applyStimulus(8'hC3, 4, 1'b1, -1, 1'b1);
    checkPacket("t11", 4, 1, 1, 4'h2);
    checkOutput("t11_toggle", toggle, 0);
    checkOutput("t11_pktlen", pkt_len, 4);
    fifo_wrnum = '0;

    $display("[TB] reset mid packet");
    @(negedge CLK); rx_act = 1'b1;
    @(negedge CLK); rx_valid = 1'b1; rx_data = 8'hC3;
    @(negedge CLK); rx_valid = 1'b0;
    checkOutput("t12_rxact_busy", fifo_rxact, 1);
    RSTn = 1'b0; rx_act = 1'b0;
    #1;
    checkOutput("t12_rxact_rst", fifo_rxact, 0);
    checkOutput("t12_pktlen_rst", pkt_len, 0);
    @(negedge CLK); RSTn = 1'b1;
    repeat (2) @(negedge CLK);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/usb_rx_pkt_ctrl.md
Name: usb_rx_pkt_ctrl

Overview:
- Receive-side sequencer placed between the ULPI/UTMI receive byte stream and the team's synchronous RX packet FIFO (commit/rollback FIFO with pktval commit and rxact-rise rollback).
- For OUT DATA0/DATA1 packets it:
  - checks the PID;
  - strips the 2 CRC bytes with a delay pipe;
  - enforces max packet size and FIFO space;
  - commits good packets, discards bad ones;
  - requests the ACK/NAK handshake for the TX side.

Parameters:
ASIZE, 9, FIFO address width; FIFO depth is 2^ASIZE bytes.
MAXPKT, 64, max data payload in bytes, excluding PID and CRC.

Ports:
CLK  in  1  system clock
RSTn  in  1  asynchronous active-low reset
rx_act  in  1  PHY receive active; high for the whole packet
rx_valid  in  1  rx_data valid this cycle
rx_data  in  8  received byte
rx_err  in  1  PHY error (bit-stuff/abort); sampled in any state
crc16_ok  in  1  external CRC16 checker result; valid on rx_act fall
ep_en  in  1  endpoint enabled; 0 gives NAK
toggle_clr  in  1  sync pulse; clears expected toggle to DATA0
fifo_wrnum  in  ASIZE+1  FIFO fill count
fifo_full  in  1  FIFO full
fifo_write  out  1  FIFO write strobe
fifo_data  out  8  FIFO write data
fifo_pktval  out  1  commit pulse
fifo_rxact  out  1  packet-active to FIFO; its rising edge rolls back uncommitted bytes
hs_req  out  1  one-cycle handshake request
hs_pid  out  4  handshake PID: ACK = 4'h2, NAK = 4'hA
pkt_len  out  ASIZE+1  payload length of the last committed packet
toggle  out  1  expected data toggle

Behaviour:
- Reset values: all outputs 0, state IDLE, toggle = 0 (DATA0).
- States: IDLE, PID, DATA, CHECK, ACK, NAK, DROP.
- IDLE
  - On rx_act rise go to PID and drive fifo_rxact = 1 (rollback edge).
  - fifo_rxact stays high until return to IDLE.
- PID: on the first rx_valid byte:
  - Invalid if rx_data[3:0] != ~rx_data[7:4], or low nibble is not DATA0 (4'h3) or DATA1 (4'hB) → go to DROP.
  - If ep_en = 0, or free = 2^ASIZE − fifo_wrnum < MAXPKT+2, set the nak flag. Continue to DATA; no FIFO writes occur while nak is set.
  - Otherwise go to DATA with bytecount = 0 and the 2-entry pipe empty. Latch pid_tog = rx_data[3].
- DATA
  - Each valid byte shifts into the 2-byte pipe.
  - When the pipe is already full, the evicted oldest byte goes out as fifo_write/fifo_data on the same cycle and bytecount increments.
  - The first write therefore occurs on the 3rd data byte, at least 3 cycles after the fifo_rxact rise. This satisfies the FIFO's 2-cycle rollback latency.
  - If bytecount would exceed MAXPKT, or fifo_full is seen at a write → DROP.
  - On rx_act fall → CHECK.
- CHECK, 1 cycle:
  - If rx_err was seen, or crc16_ok = 0, or fewer than 2 data bytes arrived → IDLE. No handshake; data stays uncommitted and the next rise discards it.
  - Else if nak → NAK.
  - Else → ACK.
- ACK
  - hs_req = 1, hs_pid = 2.
  - If pid_tog == toggle: fifo_pktval = 1, pkt_len = bytecount, toggle flips.
  - If pid_tog != toggle (retransmission): ACK without commit.
  - Next state IDLE.
  - fifo_pktval is never in the same cycle as a fifo_write; the last write is at least 1 cycle earlier.
- NAK: hs_req = 1, hs_pid = 4'hA, no commit → IDLE.
- DROP: no writes; wait for rx_act low → IDLE, no handshake.
- rx_err in any non-IDLE state → DROP.
- toggle_clr has priority over the ACK flip in the same cycle; the result is toggle = 0.
- A second rx_act rise cannot occur before IDLE. If rx_act is seen high in IDLE, treat it as a new packet.
- Reset mid-packet: the FSM returns to IDLE. The FIFO, reset by the same RSTn, is consistent.
- Width: bytecount is ASIZE+1 bits, saturating at MAXPKT+1. The free computation uses ASIZE+2 bits.

Decomposition:
- Shared package usb_pkg holds the constants:
  - PID codes: DATA0 = 4'h3, DATA1 = 4'hB, ACK = 4'h2, NAK = 4'hA.
  - State encoding.
- One sub-module, usb_crc_strip_pipe: the 2-byte delay and eviction logic, with push/flush inputs and out_valid/out_data outputs.
- The FSM stays in usb_rx_pkt_ctrl.

Test Plan:
- DATA0 packet of 4 payload bytes 11 22 33 44 plus 2 CRC bytes, crc16_ok = 1, toggle = 0:
  - exactly 4 fifo_write with data 11, 22, 33, 44;
  - fifo_pktval 1 cycle after CHECK;
  - hs_pid = 2, pkt_len = 4, toggle → 1.
- Same packet again with DATA0 while toggle = 1 → hs_pid = 2, no fifo_pktval, toggle stays 1.
- crc16_ok = 0 on an 8-byte packet → no hs_req, no pktval. The next good packet's fifo_rxact rise rolls back; the FIFO then reads only the new payload.
- fifo_wrnum = 2^ASIZE − 40 at PID → no writes, hs_pid = 4'hA, no pktval.
- 66-byte payload (MAXPKT = 64) → DROP after the 65th write attempt; no handshake.
- Bad PID byte 0xC4 → DROP, no writes. Separately, toggle_clr in the same cycle as a committing ACK → toggle = 0.
